// File: rtl/instr_mem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader: FSM states,
// stream framing constants and the default memory depth.
package instr_mem_loader_pkg;

  localparam int HDR_WIDTH           = 16;
  localparam int BYTES_PER_WORD      = 4;
  localparam int DEPTH_WORDS_DEFAULT = 256;
  localparam int BYTE_CNT_W          = $clog2(BYTES_PER_WORD);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HDR_HI = 3'd1,
    S_HDR_LO = 3'd2,
    S_DATA   = 3'd3,
    S_WRITE  = 3'd4,
    S_DONE   = 3'd5,
    S_ERR    = 3'd6
  } state_e;

  // Byte address of a word index; memory is addressed in bytes, written in words.
  function automatic logic [31:0] word_byte_addr(input logic [31:0] index);
    word_byte_addr = index * BYTES_PER_WORD;
  endfunction

endpackage

// File: rtl/instr_mem_loader_word_assembler.sv
// Big-endian byte-to-word shifter with its byte counter; flags the byte that
// completes a word so the loader can issue the write on the following cycle.
module word_assembler
  import instr_mem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_done_o
);

  logic [BYTE_CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]           word_q, word_d;
  logic                  last_byte;

  assign last_byte = (cnt_q == BYTE_CNT_W'(BYTES_PER_WORD - 1));

  // First byte of a word ends up in bits [31:24] after four shifts.
  always_comb begin
    cnt_d  = cnt_q;
    word_d = word_q;
    if (clear_i) begin
      cnt_d  = '0;
      word_d = '0;
    end else if (byte_valid_i) begin
      word_d = {word_q[23:0], byte_i};
      cnt_d  = last_byte ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      word_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      word_q <= word_d;
    end
  end

  assign word_o      = word_q;
  assign word_done_o = byte_valid_i & last_byte & ~clear_i;

endmodule

// File: rtl/instr_mem_loader.sv
// Boot loader: receives a length-prefixed big-endian program stream byte by
// byte and writes it word by word into instruction memory, holding the CPU meanwhile.
module instr_mem_loader
  import instr_mem_loader_pkg::*;
#(
  parameter int DEPTH_WORDS = DEPTH_WORDS_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam int                 IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [HDR_WIDTH:0] DEPTH_LIM = (HDR_WIDTH + 1)'(DEPTH_WORDS);

  state_e                 state_q, state_d;
  logic [HDR_WIDTH-1:0]   count_q, count_d;
  logic [IDX_W-1:0]       index_q, index_d;

  logic                   accept;
  logic                   asm_clear;
  logic                   asm_valid;
  logic [31:0]            asm_word;
  logic                   asm_done;
  logic [HDR_WIDTH-1:0]   hdr_count;
  logic [HDR_WIDTH:0]     idx_next_ext;
  logic                   last_word;

  assign accept    = rx_valid & rx_ready;
  assign asm_valid = accept & (state_q == S_DATA);
  assign hdr_count = {count_q[HDR_WIDTH-1:8], rx_data};

  // Compare in header width + 1 so a full-depth load finishes without the index wrapping.
  assign idx_next_ext = (HDR_WIDTH + 1)'(index_q) + 1'b1;
  assign last_word    = (idx_next_ext == {1'b0, count_q});

  word_assembler u_word_assembler (
    .clk          (clk),
    .reset        (reset),
    .clear_i      (asm_clear),
    .byte_valid_i (asm_valid),
    .byte_i       (rx_data),
    .word_o       (asm_word),
    .word_done_o  (asm_done)
  );

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    index_d   = index_q;
    asm_clear = 1'b0;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d   = S_HDR_HI;
          count_d   = '0;
          index_d   = '0;
          asm_clear = 1'b1;
        end
      end
      S_HDR_HI: begin
        if (accept) begin
          count_d[HDR_WIDTH-1:8] = rx_data;
          state_d                = S_HDR_LO;
        end
      end
      S_HDR_LO: begin
        if (accept) begin
          count_d = hdr_count;
          index_d = '0;
          if (hdr_count == '0) begin
            state_d = S_DONE;
          end else if ({1'b0, hdr_count} > DEPTH_LIM) begin
            state_d = S_ERR;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (asm_done) begin
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (last_word) begin
          state_d = S_DONE;
        end else begin
          index_d = index_q + 1'b1;
          state_d = S_DATA;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      count_q <= '0;
      index_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      index_q <= index_d;
    end
  end

  // Write bus is gated so address and data read as zero outside the write cycle.
  assign wr_en    = (state_q == S_WRITE);
  assign wr_addr  = wr_en ? word_byte_addr(32'(index_q)) : '0;
  assign wr_data  = wr_en ? asm_word : '0;
  assign rx_ready = (state_q == S_HDR_HI) || (state_q == S_HDR_LO) || (state_q == S_DATA);
  assign busy     = rx_ready || (state_q == S_WRITE);
  assign done     = (state_q == S_DONE);
  assign error    = (state_q == S_ERR);
  assign cpu_hold = (state_q != S_DONE);

endmodule

// File: tb/tb_instr_mem_loader.sv
// Randomized scoreboard bench for instr_mem_loader: the stimulus side models
// each load from the stream format and queues expected writes and end flags.
module tb_instr_mem_loader;

  localparam int DEPTH = 256;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        error;

  instr_mem_loader #(.DEPTH_WORDS(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .cpu_hold (cpu_hold),
    .busy     (busy),
    .done     (done),
    .error    (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  int          nCompared   = 0;
  int          nMismatched = 0;
  wr_t         expWrites[$];
  logic [3:0]  expTerm[$];
  logic [31:0] loadWords[$];

  function automatic void checkOutput(input string name, input logic [31:0] act,
                                      input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
    end
  endfunction

  // Monitor: every write and every entry into a terminal state is matched
  // against whatever the stimulus side queued.
  initial begin
    logic prevTerm;
    wr_t  w;
    prevTerm = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (wr_en) begin
        if (expWrites.size() == 0) begin
          checkOutput("stray wr_en", 32'(wr_en), 32'd0);
        end else begin
          w = expWrites.pop_front();
          checkOutput("wr_addr", wr_addr, w.addr);
          checkOutput("wr_data", wr_data, w.data);
        end
      end
      if ((done || error) && !prevTerm) begin
        if (expTerm.size() == 0) begin
          checkOutput("stray terminal", {28'd0, done, error, cpu_hold, rx_ready}, 32'd0);
        end else begin
          checkOutput("terminal flags {done,error,cpu_hold,rx_ready}",
                      {28'd0, done, error, cpu_hold, rx_ready}, {28'd0, expTerm.pop_front()});
        end
      end
      prevTerm = done || error;
    end
  end

  // All stimulus tasks start and end just after a falling edge.
  task automatic pulseStart();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic sendByte(input logic [7:0] b, input int gapMode, input bit withStart);
    int guard;
    if (gapMode == 1) repeat ($urandom_range(0, 2)) @(negedge clk);
    if (gapMode == 2) @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    if (withStart) start = 1'b1;
    guard = 0;
    while (!rx_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!rx_ready) begin
      nCompared++;
      nMismatched++;
      $display("[TB] FAIL rx_ready timeout: actual=0 required=1");
    end
    @(negedge clk);
    rx_valid = 1'b0;
    start    = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic waitTerm();
    int guard;
    guard = 0;
    while (!(done || error) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!(done || error)) begin
      nCompared++;
      nMismatched++;
      $display("[TB] FAIL load end timeout: actual=busy required=done_or_error");
    end
    repeat (2) @(negedge clk);
    checkOutput("pending writes", 32'(expWrites.size()), 32'd0);
    checkOutput("pending terminal", 32'(expTerm.size()), 32'd0);
  endtask

  // Reference model: header is the count; zero finishes empty, oversize is
  // rejected, otherwise word i lands at byte address 4*i.
  task automatic applyStimulus(input int cnt, input int gapMode, input int startAtByte);
    logic [15:0] hdr;
    logic [31:0] w;
    wr_t         e;
    int          nb;
    hdr = 16'(cnt);
    if (cnt == 0) begin
      expTerm.push_back(4'b1000);
    end else if (cnt > DEPTH) begin
      expTerm.push_back(4'b0110);
    end else begin
      while (loadWords.size() < cnt) loadWords.push_back($urandom);
      for (int i = 0; i < cnt; i++) begin
        e.addr = 32'(i * 4);
        e.data = loadWords[i];
        expWrites.push_back(e);
      end
      expTerm.push_back(4'b1000);
    end
    pulseStart();
    checkOutput("busy after start", 32'(busy), 32'd1);
    checkOutput("cpu_hold after start", 32'(cpu_hold), 32'd1);
    sendByte(hdr[15:8], gapMode, 1'b0);
    sendByte(hdr[7:0], gapMode, 1'b0);
    if (cnt > 0 && cnt <= DEPTH) begin
      nb = 0;
      for (int i = 0; i < cnt; i++) begin
        w = loadWords[i];
        for (int k = 3; k >= 0; k--) begin
          sendByte(w[8*k +: 8], gapMode, nb == startAtByte);
          nb++;
        end
      end
    end
    loadWords.delete();
    waitTerm();
  endtask

  initial begin
    int cnt;
    int r;
    logic [31:0] w;
    wr_t e;
    reset    = 1'b1;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'd0;
    #1 reset = 1'b0;
    #2;
    checkOutput("reset rx_ready", 32'(rx_ready), 32'd0);
    checkOutput("reset wr_en", 32'(wr_en), 32'd0);
    checkOutput("reset wr_addr", wr_addr, 32'd0);
    checkOutput("reset wr_data", wr_data, 32'd0);
    checkOutput("reset cpu_hold", 32'(cpu_hold), 32'd1);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset error", 32'(error), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    $display("[TB] two-word directed load");
    loadWords = '{32'h2008_0005, 32'h0000_0000};
    applyStimulus(2, 0, -1);
    checkOutput("cpu_hold after load", 32'(cpu_hold), 32'd0);

    $display("[TB] empty load and oversize header");
    applyStimulus(0, 0, -1);
    applyStimulus(257, 0, -1);

    $display("[TB] alternating rx_valid");
    loadWords = '{32'h8C01_0004};
    applyStimulus(1, 2, -1);

    $display("[TB] start pulsed during DATA");
    applyStimulus(3, 1, 2);

    $display("[TB] reset in the middle of word 1");
    loadWords = '{$urandom, $urandom, $urandom};
    e.addr = 32'd0;
    e.data = loadWords[0];
    expWrites.push_back(e);
    pulseStart();
    sendByte(8'h00, 0, 1'b0);
    sendByte(8'h03, 0, 1'b0);
    w = loadWords[0];
    for (int k = 3; k >= 0; k--) sendByte(w[8*k +: 8], 0, 1'b0);
    w = loadWords[1];
    sendByte(w[31:24], 0, 1'b0);
    sendByte(w[23:16], 0, 1'b0);
    #2 reset = 1'b0;
    #1;
    checkOutput("mid-load reset busy", 32'(busy), 32'd0);
    checkOutput("mid-load reset cpu_hold", 32'(cpu_hold), 32'd1);
    checkOutput("mid-load reset rx_ready", 32'(rx_ready), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      rx_valid = 1'b1;
      rx_data  = 8'($urandom);
      @(negedge clk);
    end
    rx_valid = 1'b0;
    checkOutput("idle after reset busy", 32'(busy), 32'd0);
    checkOutput("pending writes after reset", 32'(expWrites.size()), 32'd0);
    loadWords.delete();

    $display("[TB] randomized loads");
    for (int n = 0; n < 14; n++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0) cnt = 0;
      else if (r == 1) cnt = int'($urandom_range(DEPTH + 1, 65535));
      else cnt = int'($urandom_range(1, 8));
      applyStimulus(cnt, int'($urandom_range(0, 2)), (r == 2) ? int'($urandom_range(0, 3)) : -1);
    end

    $display("[TB] full-depth load");
    applyStimulus(DEPTH, 0, -1);
    checkOutput("cpu_hold after full load", 32'(cpu_hold), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
